dmem_responder: RTL and testbench

//  Data-memory responder for the hart's dmem port, replacing the combinational model.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 198 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder slice.
//   state_e      : responder FSM state encoding (IDLE / WAIT / RESP)
//   CNT_W        : width of the latency down-counter (LATENCY is at most 15)
//   MASK_*       : byte-lane enable constants. Bit n of a mask enables bits
//                  [8n+7:8n] of the word.
//   lane_expand  : turns a 4-bit lane mask into a 32-bit bit mask
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // Replicate each lane-enable bit across its byte.
  function automatic logic [31:0] lane_expand(input logic [3:0] mask);
    logic [31:0] bits;
    bits = '0;
    for (int n = 0; n < 4; n++) begin
      bits[8*n +: 8] = {8{mask[n]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Backing word store for the data-memory responder: DEPTH_WORDS x 32 bits,
// asynchronous read, synchronous byte-enabled write. Contents have no reset.
// Ports:
//   i_clk    in   1   write clock, rising edge
//   i_addr   in   AW  word index used for both read and write
//   o_rdata  out  32  word at i_addr (combinational)
//   i_we     in   1   write enable
//   i_wmask  in   4   byte-lane enables for the write
//   i_wdata  in   32  write data, already lane-aligned
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [3:0]    i_wmask,
  input  logic [31:0]   i_wdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  assign o_rdata = mem_q[i_addr];

  // Only the enabled byte lanes of the addressed word are touched.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int n = 0; n < 4; n++) begin
        if (i_wmask[n]) begin
          mem_q[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the hart dmem port. Accepts one word-aligned read
// or write per handshake, waits a fixed LATENCY, performs the access on the
// backing array and presents a registered response until the hart takes it.
// Only one request is ever outstanding.
// Ports:
//   i_clk        in   1   clock, rising edge
//   i_rst_n      in   1   asynchronous active-low reset
//   i_req_valid  in   1   request present
//   o_req_ready  out  1   high only while idle
//   i_req_addr   in   32  byte address (must be word aligned)
//   i_req_ren    in   1   read request
//   i_req_wen    in   1   write request
//   i_req_wdata  in   32  write data, lane-aligned
//   i_req_mask   in   4   byte-lane enables
//   o_rsp_valid  out  1   response present
//   i_rsp_ready  in   1   hart accepts response
//   o_rsp_rdata  out  32  masked read data (0 for writes and errors)
//   o_rsp_err    out  1   request rejected, memory untouched
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned    AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]    DEPTH_L      = 32'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit             SINGLE_CYCLE = (LATENCY == 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       reqAddr_q;
  logic [31:0]       reqWdata_q;
  logic              reqRen_q;
  logic              reqWen_q;
  logic [3:0]        reqMask_q;
  logic              reqReady_q;
  logic              rspValid_q;
  logic [31:0]       rspRdata_q;
  logic              rspErr_q;

  logic              accept;
  logic [31:0]       effAddr;
  logic [31:0]       effWdata;
  logic              effRen;
  logic              effWen;
  logic [3:0]        effMask;
  logic [31:0]       offset;
  logic [31:0]       wordIdx;
  logic              reqErr;
  logic              execute;
  logic              arrWe;
  logic [31:0]       arrRdata;
  logic [31:0]       rspRdata_d;
  logic              rspErr_d;

  assign accept = i_req_valid & reqReady_q;

  // The request being worked on: the live inputs while idle (needed when the
  // access executes on the accept edge itself), the captured copy otherwise.
  always_comb begin
    effAddr  = reqAddr_q;
    effWdata = reqWdata_q;
    effRen   = reqRen_q;
    effWen   = reqWen_q;
    effMask  = reqMask_q;
    if (state_q == IDLE) begin
      effAddr  = i_req_addr;
      effWdata = i_req_wdata;
      effRen   = i_req_ren;
      effWen   = i_req_wen;
      effMask  = i_req_mask;
    end
  end

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  assign offset  = effAddr - BASE_ADDR;
  assign wordIdx = offset >> 2;

  assign reqErr = (effAddr[1:0] != 2'b00) |
                  (effRen == effWen)      |
                  (effMask == 4'b0000)    |
                  (wordIdx >= DEPTH_L);

  // The access happens on the edge where the countdown finishes, or on the
  // accept edge when there is no wait phase at all.
  assign execute = (SINGLE_CYCLE && (state_q == IDLE) && accept) ||
                   ((state_q == WAIT) && (cnt_q == CNT_ONE));

  // Gate with reset so an edge seen while reset is held never writes.
  assign arrWe = i_rst_n & execute & effWen & ~reqErr;

  assign rspRdata_d = (reqErr || !effRen) ? 32'h0 : (arrRdata & lane_expand(effMask));
  assign rspErr_d   = reqErr;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_addr  (wordIdx[AW-1:0]),
    .o_rdata (arrRdata),
    .i_we    (arrWe),
    .i_wmask (effMask),
    .i_wdata (effWdata)
  );

  // Responder FSM: capture on accept, count down the latency, execute and
  // register the response, then hold it until the hart takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      reqAddr_q  <= '0;
      reqWdata_q <= '0;
      reqRen_q   <= 1'b0;
      reqWen_q   <= 1'b0;
      reqMask_q  <= '0;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            reqAddr_q  <= i_req_addr;
            reqWdata_q <= i_req_wdata;
            reqRen_q   <= i_req_ren;
            reqWen_q   <= i_req_wen;
            reqMask_q  <= i_req_mask;
            cnt_q      <= CNT_LOAD;
            reqReady_q <= 1'b0;
            if (SINGLE_CYCLE) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspRdata_q <= rspRdata_d;
              rspErr_q   <= rspErr_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            reqReady_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
          rspValid_q <= 1'b0;
          rspRdata_q <= '0;
          rspErr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = reqReady_q;
  assign o_rsp_valid = rspValid_q;
  assign o_rsp_rdata = rspRdata_q;
  assign o_rsp_err   = rspErr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Bench for dmem_responder. Instance 0 is the default build (LATENCY=2,
// 1024 words at base 0); instance 1 is a LATENCY=1 build with 16 words at
// base 0x1000 so the wrap-below-base error can be exercised.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int          LAT0   = 2;
  localparam int          LAT1   = 1;
  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam logic [31:0] BASE1  = 32'h0000_1000;
  localparam int          DEPTH0 = 1024;
  localparam int          DEPTH1 = 16;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  logic        clk;
  logic        rstN     [2];
  logic        reqValid [2];
  logic        reqReady [2];
  logic [31:0] reqAddr  [2];
  logic        reqRen   [2];
  logic        reqWen   [2];
  logic [31:0] reqWdata [2];
  logic [3:0]  reqMask  [2];
  logic        rspValid [2];
  logic        rspReady [2];
  logic [31:0] rspRdata [2];
  logic        rspErr   [2];

  int          nChecks;
  int          nFails;
  logic [31:0] modelMem [DEPTH0];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH0),
    .LATENCY     (LAT0),
    .BASE_ADDR   (BASE0)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN[0]),
    .i_req_valid (reqValid[0]),
    .o_req_ready (reqReady[0]),
    .i_req_addr  (reqAddr[0]),
    .i_req_ren   (reqRen[0]),
    .i_req_wen   (reqWen[0]),
    .i_req_wdata (reqWdata[0]),
    .i_req_mask  (reqMask[0]),
    .o_rsp_valid (rspValid[0]),
    .i_rsp_ready (rspReady[0]),
    .o_rsp_rdata (rspRdata[0]),
    .o_rsp_err   (rspErr[0])
  );

  dmem_responder #(
    .DEPTH_WORDS (DEPTH1),
    .LATENCY     (LAT1),
    .BASE_ADDR   (BASE1)
  ) dut1 (
    .i_clk       (clk),
    .i_rst_n     (rstN[1]),
    .i_req_valid (reqValid[1]),
    .o_req_ready (reqReady[1]),
    .i_req_addr  (reqAddr[1]),
    .i_req_ren   (reqRen[1]),
    .i_req_wen   (reqWen[1]),
    .i_req_wdata (reqWdata[1]),
    .i_req_mask  (reqMask[1]),
    .o_rsp_valid (rspValid[1]),
    .i_rsp_ready (rspReady[1]),
    .o_rsp_rdata (rspRdata[1]),
    .o_rsp_err   (rspErr[1])
  );

  // Free-running clock shared by both instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and keep the running tallies.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Word-level reference for instance 0: decide legality from the address
  // rules, then read or merge the enabled bytes of the addressed word.
  function automatic void refModel(input logic ren, input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] mask,
                                   output logic [31:0] expRdata, output logic expErr);
    logic [31:0] wordNum;
    wordNum  = (addr - BASE0) / 4;
    expErr   = (addr % 4 != 0) || (ren == wen) || (mask == 4'h0) || (wordNum >= DEPTH0);
    expRdata = 32'h0;
    if (!expErr) begin
      for (int n = 0; n < 4; n++) begin
        if (mask[n]) begin
          if (wen) modelMem[wordNum][8*n +: 8] = wdata[8*n +: 8];
          else     expRdata[8*n +: 8]          = modelMem[wordNum][8*n +: 8];
        end
      end
    end
  endfunction

  // Run one full request/response on instance d, checking the latency and
  // the return to idle; inputs are scrambled right after the accept edge.
  task automatic applyStimulus(input int d, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask,
                               output logic [31:0] rdata, output logic err);
    int lat;
    int guard;
    guard = 0;
    while (reqReady[d] !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checkBit("req_ready_before_issue", reqReady[d], 1'b1);
    reqValid[d] = 1'b1;
    reqRen[d]   = ren;
    reqWen[d]   = wen;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqMask[d]  = mask;
    @(posedge clk); #1;
    reqValid[d] = 1'b0;
    reqRen[d]   = 1'($urandom);
    reqWen[d]   = 1'($urandom);
    reqAddr[d]  = $urandom;
    reqWdata[d] = $urandom;
    reqMask[d]  = 4'($urandom);
    lat = 1;
    while (rspValid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'((d == 0) ? LAT0 : LAT1));
    rdata = rspRdata[d];
    err   = rspErr[d];
    rspReady[d] = 1'b1;
    @(posedge clk); #1;
    rspReady[d] = 1'b0;
    checkBit("rsp_valid_after_handshake", rspValid[d], 1'b0);
    checkBit("req_ready_after_handshake", reqReady[d], 1'b1);
  endtask

  task automatic checkResetValues(input int d, input string tag);
    checkBit({tag, "_req_ready"}, reqReady[d], 1'b1);
    checkBit({tag, "_rsp_valid"}, rspValid[d], 1'b0);
    checkOutput({tag, "_rsp_rdata"}, rspRdata[d], 32'h0);
    checkBit({tag, "_rsp_err"}, rspErr[d], 1'b0);
  endtask

  initial begin
    vec_t        vecs [12];
    logic [31:0] got;
    logic        gotErr;
    logic [31:0] expR;
    logic        expE;
    logic [31:0] held;
    int          guard;
    int          accepts;
    int          resps;

    nChecks = 0;
    nFails  = 0;
    for (int d = 0; d < 2; d++) begin
      rstN[d]     = 1'b0;
      reqValid[d] = 1'b0;
      reqRen[d]   = 1'b0;
      reqWen[d]   = 1'b0;
      reqAddr[d]  = 32'h0;
      reqWdata[d] = 32'h0;
      reqMask[d]  = 4'h0;
      rspReady[d] = 1'b0;
    end

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    checkResetValues(0, "reset0");
    checkResetValues(1, "reset1");
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    @(posedge clk); #1;
    checkResetValues(0, "post_reset0");

    // ---------------- directed table (LATENCY=2) ----------------
    vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h10, 32'h11000000, 4'h8, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 32'h11ADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hC, 32'h11AD0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h12, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h10, 32'h66666666, 4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h1000, 32'h77777777, 4'hF, 32'h0,      1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h10, 32'h88888888, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 32'h11ADBEEF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'h1, 32'h000000EF, 1'b0};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, got, gotErr);
      checkOutput($sformatf("vec%0d_rdata", i), got, vecs[i].expRdata);
      checkBit($sformatf("vec%0d_err", i), gotErr, vecs[i].expErr);
    end

    // ---------------- backpressure ----------------
    reqValid[0] = 1'b1;
    reqRen[0]   = 1'b1;
    reqWen[0]   = 1'b0;
    reqAddr[0]  = 32'h10;
    reqMask[0]  = 4'hF;
    @(posedge clk); #1;
    // A competing write is held valid the whole time; it must be ignored.
    reqRen[0]   = 1'b0;
    reqWen[0]   = 1'b1;
    reqWdata[0] = 32'h0BADF00D;
    guard = 0;
    while (rspValid[0] !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    held = rspRdata[0];
    checkOutput("bp_rdata", held, 32'h11ADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkBit("bp_rsp_valid_held", rspValid[0], 1'b1);
      checkOutput("bp_rdata_stable", rspRdata[0], held);
      checkBit("bp_req_ready_low", reqReady[0], 1'b0);
    end
    reqValid[0] = 1'b0;
    rspReady[0] = 1'b1;
    @(posedge clk); #1;
    rspReady[0] = 1'b0;
    checkBit("bp_release_rsp_valid", rspValid[0], 1'b0);
    checkBit("bp_release_req_ready", reqReady[0], 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, got, gotErr);
    checkOutput("bp_ignored_write", got, 32'h11ADBEEF);

    // ---------------- reset mid-operation ----------------
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, got, gotErr);
    checkBit("seed_0x20_err", gotErr, 1'b0);
    reqValid[0] = 1'b1;
    reqRen[0]   = 1'b0;
    reqWen[0]   = 1'b1;
    reqAddr[0]  = 32'h20;
    reqWdata[0] = 32'hCAFEF00D;
    reqMask[0]  = 4'hF;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    checkBit("wait_phase_req_ready", reqReady[0], 1'b0);
    #2 rstN[0] = 1'b0;
    #1;
    checkResetValues(0, "rst_in_wait");
    @(posedge clk); #1;
    rstN[0] = 1'b1;

    reqValid[0] = 1'b1;
    reqRen[0]   = 1'b1;
    reqWen[0]   = 1'b0;
    reqAddr[0]  = 32'h10;
    reqMask[0]  = 4'hF;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    guard = 0;
    while (rspValid[0] !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("resp_before_rst_rdata", rspRdata[0], 32'h11ADBEEF);
    #2 rstN[0] = 1'b0;
    #1;
    checkResetValues(0, "rst_in_resp");
    @(posedge clk); #1;
    rstN[0] = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, got, gotErr);
    checkOutput("dropped_write_0x20", got, 32'h12345678);

    // ---------------- randomized against the reference model ----------------
    for (int w = 0; w < 16; w++) begin
      logic [31:0] data;
      data = $urandom;
      refModel(1'b0, 1'b1, 32'(w * 4), data, 4'hF, expR, expE);
      applyStimulus(0, 1'b0, 1'b1, 32'(w * 4), data, 4'hF, got, gotErr);
      checkBit("init_err", gotErr, expE);
    end
    for (int i = 0; i < 40; i++) begin
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      int          kind;
      int          sel;
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        ren = 1'($urandom);
        wen = 1'($urandom);
      end else begin
        ren = (kind >= 3);
        wen = (kind < 3);
      end
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (sel == 1) addr = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 + 32'($urandom_range(0, 15) * 4) : 32'hFFFF_FFFC;
      else               addr = 32'($urandom_range(0, 15) * 4);
      data = $urandom;
      mask = 4'($urandom);
      refModel(ren, wen, addr, data, mask, expR, expE);
      applyStimulus(0, ren, wen, addr, data, mask, got, gotErr);
      checkOutput($sformatf("rand%0d_rdata", i), got, expR);
      checkBit($sformatf("rand%0d_err", i), gotErr, expE);
    end

    // ---------------- LATENCY=1 build, base 0x1000, 16 words ----------------
    applyStimulus(1, 1'b0, 1'b1, 32'h1004, 32'hAABBCCDD, 4'hF, got, gotErr);
    checkBit("l1_write_err", gotErr, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, got, gotErr);
    checkOutput("l1_read_rdata", got, 32'hAABBCCDD);
    applyStimulus(1, 1'b1, 1'b0, 32'h0FFC, 32'h0, 4'hF, got, gotErr);
    checkBit("l1_below_base_err", gotErr, 1'b1);
    checkOutput("l1_below_base_rdata", got, 32'h0);
    applyStimulus(1, 1'b0, 1'b1, 32'h1040, 32'h99999999, 4'hF, got, gotErr);
    checkBit("l1_past_end_err", gotErr, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 32'h103C, 32'h01020304, 4'h3, got, gotErr);
    checkBit("l1_last_word_err", gotErr, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h103C, 32'h0, 4'h3, got, gotErr);
    checkOutput("l1_last_word_rdata", got, 32'h00000304);

    // Streaming with the response side always ready: one accept every two
    // cycles, each returning the stored word.
    reqValid[1] = 1'b1;
    reqRen[1]   = 1'b1;
    reqWen[1]   = 1'b0;
    reqAddr[1]  = 32'h1004;
    reqMask[1]  = 4'hF;
    rspReady[1] = 1'b1;
    accepts = 0;
    resps   = 0;
    for (int c = 0; c < 20; c++) begin
      if (reqReady[1] === 1'b1) accepts++;
      if (rspValid[1] === 1'b1) begin
        resps++;
        checkOutput("l1_stream_rdata", rspRdata[1], 32'hAABBCCDD);
      end
      @(posedge clk); #1;
    end
    reqValid[1] = 1'b0;
    rspReady[1] = 1'b0;
    checkOutput("l1_stream_accepts", 32'(accepts), 32'd10);
    checkOutput("l1_stream_responses", 32'(resps), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
